// File: rtl/clint_vec_pkg.sv
// Shared constants and types for the core-local interrupt controller.
// Holds CSR addresses, trap causes, SYSTEM opcodes and the FSM/decision encodings.
package clint_vec_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_MRET    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    D_NONE  = 2'd0,
    D_SYNC  = 2'd1,
    D_ASYNC = 2'd2,
    D_MRET  = 2'd3
  } dec_e;

  // One registered CSR-write / redirect beat towards csr_reg and ex.
  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        int_assert;
    logic [31:0] int_addr;
  } csr_beat_t;

endpackage

// File: rtl/clint_vec_irq_pending.sv
// Per-source synchroniser, edge detector and pending latch for the interrupt inputs.
// Edge sources latch a 0->1 and hold until acked; level sources pass the synced input.
module clint_vec_irq_pending
  import clint_vec_pkg::*;
#(
  parameter int                N_IRQ       = 8,
  parameter logic [N_IRQ-1:0]  IRQ_EDGE    = N_IRQ'(1),
  parameter int                SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] ack_i,
  output logic [N_IRQ-1:0] pending_o
);

  logic [N_IRQ-1:0] sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = irq_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = irq_i;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync_d;
      end

      assign sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [N_IRQ-1:0] prev_q, prev_d, pend_q, pend_d;

  // A fresh edge wins over an ack landing in the same cycle.
  always_comb begin
    prev_d = sync;
    pend_d = '0;
    for (int i = 0; i < N_IRQ; i++)
      pend_d[i] = IRQ_EDGE[i] & ((sync[i] & ~prev_q[i]) | (pend_q[i] & ~ack_i[i]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < N_IRQ; i++)
      pending_o[i] = IRQ_EDGE[i] ? pend_q[i] : sync[i];
  end

endmodule

// File: rtl/clint_vec.sv
// Core-local interrupt controller: arbitrates sync traps, async sources and mret,
// sequences mepc/mstatus/mcause writes and issues the redirect to ex.
module clint_vec
  import clint_vec_pkg::*;
#(
  parameter int               N_IRQ       = 8,
  parameter logic [N_IRQ-1:0] IRQ_EDGE    = N_IRQ'(1),
  parameter int               SYNC_STAGES = 2,
  parameter int               CAUSE_BASE  = 16,
  parameter int               VECTORED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             illegal_inst_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_started_i,
  input  logic [31:0]      csr_mtvec,
  input  logic [31:0]      csr_mepc,
  input  logic [31:0]      csr_mstatus,
  input  logic [N_IRQ-1:0] csr_mie_i,
  input  logic             global_int_en_i,
  output logic             hold_flag_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o,
  output logic [N_IRQ-1:0] irq_ack_o
);

  function automatic logic [4:0] pick_lowest(input logic [N_IRQ-1:0] v);
    pick_lowest = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (v[i]) pick_lowest = 5'(i);
  endfunction

  logic [N_IRQ-1:0] pending, active;
  logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic [4:0]       pick, sel_idx_q, sel_idx_d;
  logic [31:0]      epc_q, epc_d, cause_q, cause_d;
  logic             async_q, async_d, sync_trap;
  state_e           state_q, state_d;
  dec_e             dec;
  csr_beat_t        out_q, out_d;

  clint_vec_irq_pending #(
    .N_IRQ      (N_IRQ),
    .IRQ_EDGE   (IRQ_EDGE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .irq_i    (irq_i),
    .ack_i    (irq_ack_q),
    .pending_o(pending)
  );

  // A sync trap behind a busy divider is deferred, not converted into an async pick.
  always_comb begin
    sync_trap = (illegal_inst_i | (inst_i == INST_ECALL) | (inst_i == INST_EBREAK))
                & ~div_started_i;
    active    = pending & csr_mie_i;
    pick      = pick_lowest(active);
    dec       = D_NONE;
    if (state_q == S_IDLE) begin
      if (sync_trap)                      dec = D_SYNC;
      else if (|active && global_int_en_i) dec = D_ASYNC;
      else if (inst_i == INST_MRET)       dec = D_MRET;
    end
  end

  assign hold_flag_o = (dec != D_NONE) | (state_q != S_IDLE);

  // Next state and the trap context captured when leaving IDLE.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    sel_idx_d = sel_idx_q;
    async_d   = async_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (dec)
          D_SYNC: begin
            state_d = S_MEPC;
            async_d = 1'b0;
            epc_d   = jump_flag_i ? jump_addr_i - 32'd4 : inst_addr_i;
            if (illegal_inst_i)              cause_d = CAUSE_ILLEGAL;
            else if (inst_i == INST_EBREAK)  cause_d = CAUSE_EBREAK;
            else                             cause_d = CAUSE_ECALL;
          end
          D_ASYNC: begin
            state_d   = S_MEPC;
            async_d   = 1'b1;
            sel_idx_d = pick;
            epc_d     = jump_flag_i   ? jump_addr_i :
                        div_started_i ? inst_addr_i - 32'd4 : inst_addr_i;
            cause_d   = {1'b1, 31'(CAUSE_BASE) + 31'(pick)};
          end
          D_MRET:  state_d = S_MRET;
          default: ;
        endcase
      end
      S_MEPC:    state_d = S_MSTATUS;
      S_MSTATUS: state_d = S_MCAUSE;
      S_MCAUSE:  state_d = S_IDLE;
      S_MRET:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output beat for the current state; registered, so it lands one cycle later.
  always_comb begin
    logic [31:0] base;
    base      = {csr_mtvec[31:2], 2'b00};
    out_d     = '0;
    irq_ack_d = '0;
    unique case (state_q)
      S_MEPC: begin
        out_d.we    = 1'b1;
        out_d.waddr = {20'h0, CSR_MEPC};
        out_d.data  = epc_q;
      end
      S_MSTATUS: begin
        out_d.we    = 1'b1;
        out_d.waddr = {20'h0, CSR_MSTATUS};
        out_d.data  = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4],
                       1'b0, csr_mstatus[2:0]};
      end
      S_MCAUSE: begin
        out_d.we         = 1'b1;
        out_d.waddr      = {20'h0, CSR_MCAUSE};
        out_d.data       = cause_q;
        out_d.int_assert = 1'b1;
        out_d.int_addr   = ((VECTORED_EN != 0) && async_q && (csr_mtvec[1:0] == 2'b01))
                           ? base + {cause_q[29:0], 2'b00} : base;
        if (async_q) irq_ack_d = N_IRQ'(1) << sel_idx_q;
      end
      S_MRET: begin
        out_d.we         = 1'b1;
        out_d.waddr      = {20'h0, CSR_MSTATUS};
        out_d.data       = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4],
                            csr_mstatus[7], csr_mstatus[2:0]};
        out_d.int_assert = 1'b1;
        out_d.int_addr   = csr_mepc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      sel_idx_q <= '0;
      async_q   <= 1'b0;
      out_q     <= '0;
      irq_ack_q <= '0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      sel_idx_q <= sel_idx_d;
      async_q   <= async_d;
      out_q     <= out_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign we_o         = out_q.we;
  assign waddr_o      = out_q.waddr;
  assign data_o       = out_q.data;
  assign int_assert_o = out_q.int_assert;
  assign int_addr_o   = out_q.int_addr;
  assign irq_ack_o    = irq_ack_q;

endmodule

// File: tb/tb_clint_vec.sv
// Directed bench for clint_vec: sync-trap vector table plus hand sequences for
// async arbitration, divider deferral, mret and mid-sequence reset.
module tb_clint_vec;
  import clint_vec_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq, mie, irq_ack_o;
  logic [31:0] inst, iaddr, jaddr, mtvec, mepc, ms;
  logic        illegal, jump, div;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  clint_vec #(
    .N_IRQ(8), .IRQ_EDGE(8'h2D), .SYNC_STAGES(2), .CAUSE_BASE(16), .VECTORED_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .inst_i(inst), .inst_addr_i(iaddr),
    .illegal_inst_i(illegal), .jump_flag_i(jump), .jump_addr_i(jaddr),
    .div_started_i(div), .csr_mtvec(mtvec), .csr_mepc(mepc), .csr_mstatus(ms),
    .csr_mie_i(mie), .global_int_en_i(ms[3]), .hold_flag_o(hold_flag_o),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .int_assert_o(int_assert_o),
    .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic        ill, jmp;
    logic [31:0] jaddr, iaddr, mtvec, ms;
    logic [31:0] e_epc, e_ms, e_cause, e_addr;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one cycle, negedge to negedge; a minimal csr_reg applies the write.
  task automatic tick();
    logic        w;
    logic [31:0] a, d;
    w = we_o; a = waddr_o; d = data_o;
    @(posedge clk); #1;
    if (w && a == {20'h0, CSR_MSTATUS}) ms = d;
    if (w && a == {20'h0, CSR_MEPC})    mepc = d;
    @(negedge clk);
  endtask

  task automatic clear_inst();
    inst = NOP; illegal = 1'b0; jump = 1'b0;
  endtask

  task automatic wait_hold(input string nm, input int budget);
    int k;
    k = 0;
    while (!hold_flag_o && k < budget) begin tick(); k++; end
    n_chk++;
    if (!hold_flag_o) begin
      n_fail++;
      $display("FAIL %s: hold never rose within %0d cycles", nm, budget);
    end
  endtask

  // Called in the decision cycle T; checks T+1 .. T+5.
  task automatic check_trap(input string nm, input logic [31:0] e_epc, input logic [31:0] e_ms,
                            input logic [31:0] e_cause, input logic [31:0] e_addr,
                            input logic [7:0] e_ack);
    chk({nm, " hold@T"}, 32'(hold_flag_o), 32'd1);
    tick(); clear_inst();
    chk({nm, " hold@T+1"}, 32'(hold_flag_o), 32'd1);
    chk({nm, " we@T+1"}, 32'(we_o), 32'd0);
    tick();
    chk({nm, " we@T+2"}, 32'(we_o), 32'd1);
    chk({nm, " waddr mepc"}, waddr_o, {20'h0, CSR_MEPC});
    chk({nm, " mepc"}, data_o, e_epc);
    tick();
    chk({nm, " waddr mstatus"}, waddr_o, {20'h0, CSR_MSTATUS});
    chk({nm, " mstatus"}, data_o, e_ms);
    chk({nm, " early redirect"}, 32'(int_assert_o), 32'd0);
    tick();
    chk({nm, " waddr mcause"}, waddr_o, {20'h0, CSR_MCAUSE});
    chk({nm, " mcause"}, data_o, e_cause);
    chk({nm, " int_assert"}, 32'(int_assert_o), 32'd1);
    chk({nm, " int_addr"}, int_addr_o, e_addr);
    chk({nm, " irq_ack"}, 32'(irq_ack_o), 32'(e_ack));
    tick();
    chk({nm, " int_assert low"}, 32'(int_assert_o), 32'd0);
    chk({nm, " we low"}, 32'(we_o), 32'd0);
    chk({nm, " ack low"}, 32'(irq_ack_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{INST_ECALL, 1'b0, 1'b0, 32'h0, 32'h100, 32'h1000, 32'h8,
               32'h100, 32'h80, 32'd11, 32'h1000};
    tbl[1] = '{INST_EBREAK, 1'b0, 1'b1, 32'h208, 32'h500, 32'h3001, 32'h0,
               32'h204, 32'h0, 32'd3, 32'h3000};
    tbl[2] = '{NOP, 1'b1, 1'b1, 32'h2, 32'h40, 32'h4003, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'hFFFF_FFF7, 32'd2, 32'h4000};
    tbl[3] = '{INST_ECALL, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFC, 32'h88,
               32'h8000_0000, 32'h80, 32'd11, 32'hFFFF_FFFC};

    rst = 1'b0; irq = '0; mie = '0; div = 1'b0; jaddr = '0; iaddr = '0;
    mtvec = '0; mepc = '0; ms = '0;
    clear_inst();
    @(negedge clk);
    chk("reset hold", 32'(hold_flag_o), 32'd0);
    chk("reset we", 32'(we_o), 32'd0);
    chk("reset data", data_o, 32'd0);
    chk("reset int_assert", 32'(int_assert_o), 32'd0);
    chk("reset int_addr", int_addr_o, 32'd0);
    chk("reset ack", 32'(irq_ack_o), 32'd0);
    tick(); rst = 1'b1; tick();

    // Synchronous traps from the table.
    for (int v = 0; v < 4; v++) begin
      inst = tbl[v].inst; illegal = tbl[v].ill; jump = tbl[v].jmp; jaddr = tbl[v].jaddr;
      iaddr = tbl[v].iaddr; mtvec = tbl[v].mtvec; ms = tbl[v].ms;
      #1;
      check_trap($sformatf("sync%0d", v), tbl[v].e_epc, tbl[v].e_ms,
                 tbl[v].e_cause, tbl[v].e_addr, 8'h00);
    end

    // Vectored edge interrupt on source 3.
    mtvec = 32'h2001; mie = 8'hFF; ms = 32'h8; iaddr = 32'h500;
    irq = 8'h08;
    wait_hold("irq3 wait", 10);
    check_trap("irq3", 32'h500, 32'h80, 32'h8000_0013, 32'h204C, 8'h08);
    irq = '0;
    tick(); tick(); tick();
    ms = 32'h8; #1;
    chk("irq3 pending cleared", 32'(hold_flag_o), 32'd0);

    // Two edges together: source 2 first, source 5 after MIE is restored.
    irq = 8'h24;
    wait_hold("irq2 wait", 10);
    check_trap("irq2", 32'h500, 32'h80, 32'h8000_0012, 32'h2048, 8'h04);
    irq = '0;
    tick(); tick();
    chk("irq5 masked by MIE", 32'(hold_flag_o), 32'd0);
    div = 1'b1; ms = 32'h8; #1;
    check_trap("irq5", 32'h4FC, 32'h80, 32'h8000_0015, 32'h2054, 8'h20);
    div = 1'b0;

    // Level source 6: no latch once the input drops.
    ms = 32'h8; irq = 8'h40;
    wait_hold("irq6 wait", 10);
    check_trap("irq6", 32'h500, 32'h80, 32'h8000_0016, 32'h2058, 8'h40);
    irq = '0;
    tick(); tick(); tick(); tick();
    ms = 32'h8; #1;
    chk("irq6 level dropped", 32'(hold_flag_o), 32'd0);

    // ebreak deferred while the divider is busy.
    inst = INST_EBREAK; div = 1'b1; iaddr = 32'h600; #1;
    chk("ebreak div hold", 32'(hold_flag_o), 32'd0);
    tick();
    chk("ebreak div hold2", 32'(hold_flag_o), 32'd0);
    tick();
    div = 1'b0; #1;
    check_trap("ebreak", 32'h600, 32'h80, 32'd3, 32'h2000, 8'h00);

    // mret: redirect to mepc two cycles after detection.
    ms = 32'h80; mepc = 32'h400; inst = INST_MRET; #1;
    chk("mret hold@T", 32'(hold_flag_o), 32'd1);
    tick(); clear_inst();
    chk("mret hold@T+1", 32'(hold_flag_o), 32'd1);
    chk("mret early redirect", 32'(int_assert_o), 32'd0);
    tick();
    chk("mret we", 32'(we_o), 32'd1);
    chk("mret waddr", waddr_o, {20'h0, CSR_MSTATUS});
    chk("mret mstatus", data_o, 32'h88);
    chk("mret int_assert", 32'(int_assert_o), 32'd1);
    chk("mret int_addr", int_addr_o, 32'h400);
    tick();
    chk("mret int_assert low", 32'(int_assert_o), 32'd0);
    chk("mret hold low", 32'(hold_flag_o), 32'd0);

    // Reset while the mstatus beat is being prepared.
    ms = 32'h8; inst = INST_ECALL; iaddr = 32'h700; #1;
    chk("rst seq hold", 32'(hold_flag_o), 32'd1);
    tick(); clear_inst();
    tick();
    chk("rst seq mepc beat", data_o, 32'h700);
    rst = 1'b0; #1;
    chk("rst we", 32'(we_o), 32'd0);
    chk("rst data", data_o, 32'd0);
    chk("rst waddr", waddr_o, 32'd0);
    chk("rst int_assert", 32'(int_assert_o), 32'd0);
    chk("rst hold", 32'(hold_flag_o), 32'd0);
    tick(); rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post-rst int_assert c%0d", c), 32'(int_assert_o), 32'd0);
      chk($sformatf("post-rst we c%0d", c), 32'(we_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
